navigation_sm: RTL and testbench
================================

NAVIGATION_SM -- requirements
Module: navigation_sm

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive stable cycles required to accept a button level change; legal range 2..2^20.
REQ-002 The block SHALL have port CLK, input, 1, the system clock; all state SHALL change only on the rising edge.
REQ-003 The block SHALL have port RESET, input, 1, the synchronous active-low reset; it SHALL be sampled on the CLK rising edge only.
REQ-004 The block SHALL have ports LEFT, RIGHT, UP and DOWN, each input, 1, a raw asynchronous push-button level with 1 meaning pressed.
REQ-005 The block SHALL have port STATE, input, 2, the master game state: 00 IDLE, 01 PLAY, 10 WIN, 11 reserved.
REQ-006 The block SHALL have port DIRECTION, output, 2, the registered snake heading: 00 UP, 01 RIGHT, 10 DOWN, 11 LEFT.
REQ-007 The block SHALL have port DIR_CHANGED, output, 1, a registered one-cycle pulse marking the first cycle of a new DIRECTION value.

Function
REQ-008 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-009 Each button SHALL have a debounced level (reset 0) and a saturating counter of width clog2(DEBOUNCE_CYCLES+1).
- Counter: cleared when the synchronized level equals the debounced level; otherwise incremented.
- Debounced level: toggles, and the counter clears, on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-010 A press event SHALL be a one-cycle 0->1 transition of a debounced level.
- Release transitions SHALL produce no event.
- A held button SHALL produce exactly one event.
- A pulse shorter than DEBOUNCE_CYCLES cycles SHALL produce no event.
REQ-011 The direction FSM SHALL have four states (UP, RIGHT, DOWN, LEFT), encoded as DIRECTION, with reset state RIGHT.
REQ-012 While STATE = IDLE, DIRECTION SHALL be forced to RIGHT on every edge; press events SHALL be discarded and SHALL NOT be queued.
REQ-013 While STATE = WIN or 11, DIRECTION SHALL hold; press events SHALL be discarded.
REQ-014 While STATE = PLAY, press events in a given cycle SHALL be filtered as follows.
- Discard a press equal to the current DIRECTION.
- Discard a press opposite to the current DIRECTION (UP/DOWN, LEFT/RIGHT).
- Of the remaining presses, the highest priority SHALL win: UP > RIGHT > DOWN > LEFT.
- DIRECTION SHALL update on the next edge.
REQ-015 DIR_CHANGED SHALL be 1 exactly in the cycle that DIRECTION holds a value different from the previous cycle, including the forced return to RIGHT on entry to IDLE; otherwise 0.
REQ-016 Latency, with a raw button rising before edge k and held stable: DIRECTION SHALL update no earlier than edge k+DEBOUNCE_CYCLES and no later than edge k+DEBOUNCE_CYCLES+4.
REQ-017 An IDLE->PLAY transition SHALL start with DIRECTION = RIGHT. Only presses whose event occurs while STATE = PLAY SHALL take effect.
REQ-018 A button held through reset deassertion SHALL be treated as a fresh press: one event after DEBOUNCE_CYCLES stable cycles.

Reset
REQ-019 While RESET = 0 at an edge, the following SHALL clear on that edge, regardless of inputs:
- synchronizers, debounced levels, counters and press events to 0;
- DIRECTION to 01;
- DIR_CHANGED to 0.
REQ-020 Reset asserted mid-debounce SHALL discard the partial count; no event SHALL result from pre-reset activity.

Verification
REQ-021 Reset check: RESET = 0 for 3 cycles with all buttons high, STATE = PLAY -> DIRECTION = 01 and DIR_CHANGED = 0 throughout reset.
REQ-022 Debounced turn: STATE = PLAY, DEBOUNCE_CYCLES = 16, UP held for 40 cycles -> DIRECTION goes 01->00 within 16..20 edges, a single DIR_CHANGED pulse, and no further change.
REQ-023 Glitch rejection: DOWN pulsed high for 10 cycles, then low for 30 -> DIRECTION stays 01; DIR_CHANGED stays 0.
REQ-024 Reversal and priority:
- From RIGHT, press LEFT -> no change.
- Then UP and LEFT pressed simultaneously -> DIRECTION = 00.
- Then DOWN -> no change.
- Then LEFT -> DIRECTION = 11.
REQ-025 Mode gating:
- STATE = IDLE, press UP -> DIRECTION stays 01.
- Switch to PLAY with UP still held -> no change.
- From DIRECTION = 11, STATE -> IDLE -> DIRECTION = 01 with one DIR_CHANGED pulse.
- STATE = WIN -> DIRECTION frozen under all presses.
REQ-026 Reset mid-debounce: UP high for 10 cycles, RESET = 0 for 1 cycle, UP released -> no DIRECTION change ever observed.

Source files
------------

// File: rtl/navigation_sm.sv
// Snake heading controller: synchronizes and debounces four push-buttons, turns
// press events into a filtered, prioritised heading gated by the game state.
module navigation_sm #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       UP,
  input  logic       DOWN,
  input  logic [1:0] STATE,
  output logic [1:0] DIRECTION,
  output logic       DIR_CHANGED
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  // Button vectors are indexed by the heading code they request.
  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       deb;
  logic [3:0]       deb_next;
  logic [3:0]       press;
  logic [3:0]       allowed;
  logic [CNT_W-1:0] cnt      [4];
  logic [CNT_W-1:0] cnt_next [4];
  logic [1:0]       opp_dir;
  dir_e             dir_q;
  dir_e             dir_next;

  assign raw       = {LEFT, DOWN, RIGHT, UP};
  assign DIRECTION = dir_q;
  assign opp_dir   = dir_q ^ 2'b10;

  // Debounce: accept a level change only after CNT_LAST+1 consecutive mismatches.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      deb_next[i] = deb[i];
      cnt_next[i] = '0;
      if (sync2[i] != deb[i]) begin
        if (cnt[i] == CNT_LAST) begin
          deb_next[i] = ~deb[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Drop same and reverse headings, then UP > RIGHT > DOWN > LEFT.
  always_comb begin
    allowed          = press;
    allowed[dir_q]   = 1'b0;
    allowed[opp_dir] = 1'b0;
    dir_next         = dir_q;
    if (allowed[0]) begin
      dir_next = DIR_UP;
    end else if (allowed[1]) begin
      dir_next = DIR_RIGHT;
    end else if (allowed[2]) begin
      dir_next = DIR_DOWN;
    end else if (allowed[3]) begin
      dir_next = DIR_LEFT;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sync1       <= '0;
      sync2       <= '0;
      deb         <= '0;
      press       <= '0;
      dir_q       <= DIR_RIGHT;
      DIR_CHANGED <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb   <= deb_next;
      press <= deb_next & ~deb;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= cnt_next[i];
      end
      case (STATE)
        ST_IDLE: begin
          dir_q       <= DIR_RIGHT;
          DIR_CHANGED <= (dir_q != DIR_RIGHT);
        end
        ST_PLAY: begin
          dir_q       <= dir_next;
          DIR_CHANGED <= (dir_next != dir_q);
        end
        default: DIR_CHANGED <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_navigation_sm.sv
// Directed bench for navigation_sm: reset, debounce latency, glitch rejection,
// reversal/priority filtering, mode gating and reset during debounce.
module tb_navigation_sm;

  localparam int D = 16;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_WIN  = 2'b10;
  localparam logic [1:0] S_RSV  = 2'b11;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       left, right, up, down;
  logic [1:0] state;
  logic [1:0] direction;
  logic       dir_changed;

  int tests_run = 0;
  int tests_failed = 0;

  // Observations accumulated by run()
  int         dir_changes;
  int         pulses;
  int         first_change;
  int         pulse_mismatch = 0;
  logic [1:0] prev_dir;

  navigation_sm #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK(clk), .RESET(reset_n), .LEFT(left), .RIGHT(right), .UP(up), .DOWN(down),
    .STATE(state), .DIRECTION(direction), .DIR_CHANGED(dir_changed)
  );

  always #5 clk = ~clk;

  // Advance n edges, sampling at each following negedge.
  task automatic run(input int n);
    dir_changes  = 0;
    pulses       = 0;
    first_change = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (direction !== prev_dir) begin
        dir_changes++;
        if (first_change < 0) first_change = i;
      end
      if (dir_changed === 1'b1) pulses++;
      if (dir_changed !== (direction !== prev_dir)) pulse_mismatch++;
      prev_dir = direction;
    end
  endtask

  task automatic do_reset();
    {left, right, up, down} = 4'b0000;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    prev_dir = direction;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    state   = S_PLAY;
    {left, right, up, down} = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++; if (direction !== 2'b01) begin tests_failed++; $display("FAIL reset_dir cycle %0d got %b want 01", c, direction); end
      tests_run++; if (dir_changed !== 1'b0) begin tests_failed++; $display("FAIL reset_pulse cycle %0d got %b want 0", c, dir_changed); end
    end
    // Buttons held through reset release count as fresh presses; UP wins.
    reset_n  = 1'b1;
    prev_dir = direction;
    run(30);
    tests_run++; if (direction !== 2'b00) begin tests_failed++; $display("FAIL held_through_reset_dir got %b want 00", direction); end
    tests_run++; if (dir_changes !== 1) begin tests_failed++; $display("FAIL held_through_reset_changes got %0d want 1", dir_changes); end
    do_reset();
    @(negedge clk);
    tests_run++; if (direction !== 2'b01) begin tests_failed++; $display("FAIL re_reset_dir got %b want 01", direction); end
  endtask

  task automatic test_debounced_turn();
    do_reset();
    state = S_PLAY;
    up    = 1'b1;
    run(40);
    tests_run++; if (first_change < D + 1 || first_change > D + 5) begin tests_failed++; $display("FAIL turn_latency got edge %0d want %0d..%0d", first_change, D + 1, D + 5); end
    tests_run++; if (direction !== 2'b00) begin tests_failed++; $display("FAIL turn_dir got %b want 00", direction); end
    tests_run++; if (dir_changes !== 1) begin tests_failed++; $display("FAIL turn_changes got %0d want 1", dir_changes); end
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL turn_pulses got %0d want 1", pulses); end
    up = 1'b0;
    run(30);
    tests_run++; if (dir_changes !== 0) begin tests_failed++; $display("FAIL release_changes got %0d want 0", dir_changes); end
  endtask

  task automatic test_glitch();
    do_reset();
    state = S_PLAY;
    down  = 1'b1;
    run(10);
    down = 1'b0;
    run(30);
    tests_run++; if (direction !== 2'b01) begin tests_failed++; $display("FAIL glitch_dir got %b want 01", direction); end
    tests_run++; if (dir_changes !== 0) begin tests_failed++; $display("FAIL glitch_changes got %0d want 0", dir_changes); end
    tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
  endtask

  task automatic test_priority();
    int total;
    do_reset();
    state = S_PLAY;
    left  = 1'b1; run(25); total = dir_changes;
    left  = 1'b0; run(25); total += dir_changes;
    tests_run++; if (direction !== 2'b01 || total !== 0) begin tests_failed++; $display("FAIL reverse_left got %b/%0d want 01/0", direction, total); end
    {up, left} = 2'b11; run(25); total = dir_changes;
    {up, left} = 2'b00; run(25); total += dir_changes;
    tests_run++; if (direction !== 2'b00 || total !== 1) begin tests_failed++; $display("FAIL up_left_priority got %b/%0d want 00/1", direction, total); end
    down = 1'b1; run(25); total = dir_changes;
    down = 1'b0; run(25); total += dir_changes;
    tests_run++; if (direction !== 2'b00 || total !== 0) begin tests_failed++; $display("FAIL reverse_down got %b/%0d want 00/0", direction, total); end
    left = 1'b1; run(25); total = dir_changes;
    left = 1'b0; run(25); total += dir_changes;
    tests_run++; if (direction !== 2'b11 || total !== 1) begin tests_failed++; $display("FAIL turn_left got %b/%0d want 11/1", direction, total); end
  endtask

  task automatic test_mode_gating();
    int total;
    do_reset();
    state = S_IDLE;
    up    = 1'b1; run(30);
    tests_run++; if (direction !== 2'b01 || dir_changes !== 0) begin tests_failed++; $display("FAIL idle_press got %b/%0d want 01/0", direction, dir_changes); end
    state = S_PLAY; run(30);
    tests_run++; if (direction !== 2'b01 || dir_changes !== 0) begin tests_failed++; $display("FAIL idle_to_play_held got %b/%0d want 01/0", direction, dir_changes); end
    up = 1'b0; run(25);
    up = 1'b1; run(25); up = 1'b0; run(25);
    left = 1'b1; run(25); left = 1'b0; run(25);
    tests_run++; if (direction !== 2'b11) begin tests_failed++; $display("FAIL setup_left got %b want 11", direction); end
    state = S_IDLE; run(5);
    tests_run++; if (direction !== 2'b01 || first_change !== 1) begin tests_failed++; $display("FAIL idle_force got %b edge %0d want 01 edge 1", direction, first_change); end
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL idle_force_pulses got %0d want 1", pulses); end
    state = S_PLAY;
    up = 1'b1; run(25); up = 1'b0; run(25);
    state = S_WIN;
    right = 1'b1; run(25); total = dir_changes; right = 1'b0; run(25); total += dir_changes;
    left  = 1'b1; run(25); total += dir_changes; left  = 1'b0; run(25); total += dir_changes;
    tests_run++; if (direction !== 2'b00 || total !== 0) begin tests_failed++; $display("FAIL win_frozen got %b/%0d want 00/0", direction, total); end
    state = S_RSV;
    right = 1'b1; run(25); total = dir_changes; right = 1'b0; run(25); total += dir_changes;
    tests_run++; if (direction !== 2'b00 || total !== 0) begin tests_failed++; $display("FAIL reserved_frozen got %b/%0d want 00/0", direction, total); end
  endtask

  task automatic test_reset_mid_debounce();
    int total;
    do_reset();
    state = S_PLAY;
    up    = 1'b1; run(10); total = dir_changes;
    reset_n = 1'b0; run(1); total += dir_changes;
    reset_n = 1'b1; up = 1'b0; run(40); total += dir_changes;
    tests_run++; if (direction !== 2'b01 || total !== 0) begin tests_failed++; $display("FAIL reset_mid_debounce got %b/%0d want 01/0", direction, total); end
  endtask

  task automatic test_pulse_consistency();
    tests_run++; if (pulse_mismatch !== 0) begin tests_failed++; $display("FAIL pulse_vs_change got %0d cycles want 0", pulse_mismatch); end
  endtask

  initial begin
    test_reset();
    test_debounced_turn();
    test_glitch();
    test_priority();
    test_mode_gating();
    test_reset_mid_debounce();
    test_pulse_consistency();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
